// File: rtl/ldx_seq.sv
// Block-transfer sequencer (LDI/LDD/LDIR/LDDR): per byte READ, WRITE, then HL/DE/BC updates via external alu16.
// Latency 5 cycles/byte at zero wait plus start and DONE cycles; memory requests hold until acked, start ignored while busy.
module ldx_seq #(
    parameter logic [2:0] OP_INC    = 3'd0,
    parameter logic [2:0] OP_DEC    = 3'd1,
    parameter logic [2:0] OP_DEC_LD = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] bc_in,
    input  logic [15:0] de_in,
    input  logic [15:0] hl_in,
    input  logic [7:0]  a_in,
    input  logic [7:0]  flags_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd_req,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    output logic        mem_wr_req,
    output logic [7:0]  mem_wr_data,
    input  logic        mem_wr_ack,
    output logic [15:0] alu_arg1,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_flags_in,
    input  logic [15:0] alu_out,
    input  logic [7:0]  alu_flags_out,
    output logic [15:0] bc_out,
    output logic [15:0] de_out,
    output logic [15:0] hl_out,
    output logic [7:0]  flags_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_UPD_HL, S_UPD_DE, S_UPD_BC, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bc_q, bc_d, de_q, de_d, hl_q, hl_d;
    logic [7:0]  flags_q, flags_d, a_q, a_d, data_q, data_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [15:0] alu_arg1_q, alu_arg1_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_fin_q, alu_fin_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [7:0]  n_sum;
    logic [2:0]  step_op;

    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        de_d    = de_q;
        hl_d    = hl_q;
        flags_d = flags_q;
        a_d     = a_q;
        data_d  = data_q;
        mode_d  = mode_q;
        step_op = mode_q[0] ? OP_DEC : OP_INC;
        n_sum   = data_q + a_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bc_d    = bc_in;
                    de_d    = de_in;
                    hl_d    = hl_in;
                    flags_d = flags_in;
                    a_d     = a_in;
                    mode_d  = mode;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (mem_rd_ack) begin
                    data_d  = mem_rd_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_wr_ack) state_d = S_UPD_HL;
            end
            S_UPD_HL: begin
                hl_d    = alu_out;
                state_d = S_UPD_DE;
            end
            S_UPD_DE: begin
                de_d    = alu_out;
                state_d = S_UPD_BC;
            end
            S_UPD_BC: begin
                bc_d = alu_out;
                // Undocumented F5/F3 come from (byte + A), not from the ALU
                flags_d = {alu_flags_out[7:6], n_sum[1], alu_flags_out[4],
                           n_sum[3], alu_flags_out[2:0]};
                state_d = (mode_q[1] && (alu_out != 16'd0)) ? S_READ : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state and next register values
        mem_addr_d = mem_addr_q;
        wr_data_d  = wr_data_q;
        rd_req_d   = (state_d == S_READ);
        wr_req_d   = (state_d == S_WRITE);
        if (state_d == S_READ) mem_addr_d = hl_d;
        if (state_d == S_WRITE) begin
            mem_addr_d = de_d;
            wr_data_d  = data_d;
        end

        alu_arg1_d = 16'd0;
        alu_op_d   = OP_INC;
        alu_fin_d  = flags_d;
        case (state_d)
            S_UPD_HL: begin
                alu_arg1_d = hl_d;
                alu_op_d   = step_op;
            end
            S_UPD_DE: begin
                alu_arg1_d = de_d;
                alu_op_d   = step_op;
            end
            S_UPD_BC: begin
                alu_arg1_d = bc_d;
                alu_op_d   = OP_DEC_LD;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bc_q       <= 16'd0;
            de_q       <= 16'd0;
            hl_q       <= 16'd0;
            flags_q    <= 8'd0;
            a_q        <= 8'd0;
            data_q     <= 8'd0;
            mode_q     <= 2'd0;
            mem_addr_q <= 16'd0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_data_q  <= 8'd0;
            alu_arg1_q <= 16'd0;
            alu_op_q   <= OP_INC;
            alu_fin_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            de_q       <= de_d;
            hl_q       <= hl_d;
            flags_q    <= flags_d;
            a_q        <= a_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            mem_addr_q <= mem_addr_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            wr_data_q  <= wr_data_d;
            alu_arg1_q <= alu_arg1_d;
            alu_op_q   <= alu_op_d;
            alu_fin_q  <= alu_fin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_rd_req   = rd_req_q;
    assign mem_wr_req   = wr_req_q;
    assign mem_wr_data  = wr_data_q;
    assign alu_arg1     = alu_arg1_q;
    assign alu_op       = alu_op_q;
    assign alu_flags_in = alu_fin_q;
    assign bc_out       = bc_q;
    assign de_out       = de_q;
    assign hl_out       = hl_q;
    assign flags_out    = flags_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ldx_seq.sv
// Bench for ldx_seq: byte memory and alu16 behaviour around the DUT, transfers checked against a byte-level model.
module tb_ldx_seq;
    localparam logic [2:0] OP_INC = 3'd0, OP_DEC = 3'd1, OP_DEC_LD = 3'd3;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] bc_in = 16'd0, de_in = 16'd0, hl_in = 16'd0;
    logic [7:0]  a_in = 8'd0, flags_in = 8'd0;
    logic [15:0] mem_addr;
    logic        mem_rd_req, mem_wr_req;
    logic        mem_rd_ack = 1'b0, mem_wr_ack = 1'b0;
    logic [7:0]  mem_rd_data = 8'd0, mem_wr_data;
    logic [15:0] alu_arg1, alu_out;
    logic [2:0]  alu_op;
    logic [7:0]  alu_flags_in, alu_flags_out;
    logic [15:0] bc_out, de_out, hl_out;
    logic [7:0]  flags_out;
    logic        busy, done;

    int total = 0, bad = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ovl [logic [15:0]];
    logic [15:0] got_addr[$], exp_addr[$];
    logic [7:0]  got_dat[$], exp_dat[$];
    logic [15:0] exp_hl, exp_de, exp_bc;
    logic [7:0]  exp_f;
    int          exp_cyc, run_cyc, proto_err;
    bit          run_to, done_after, busy_after;

    always #5 clk = ~clk;

    ldx_seq #(.OP_INC(OP_INC), .OP_DEC(OP_DEC), .OP_DEC_LD(OP_DEC_LD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .bc_in(bc_in), .de_in(de_in), .hl_in(hl_in), .a_in(a_in), .flags_in(flags_in),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .alu_arg1(alu_arg1), .alu_op(alu_op),
        .alu_flags_in(alu_flags_in), .alu_out(alu_out), .alu_flags_out(alu_flags_out),
        .bc_out(bc_out), .de_out(de_out), .hl_out(hl_out), .flags_out(flags_out),
        .busy(busy), .done(done)
    );

    // alu16 stand-in: DEC_LD clears H and N, sets PV when the decremented count is non-zero
    always_comb begin
        alu_out       = alu_arg1;
        alu_flags_out = alu_flags_in;
        case (alu_op)
            OP_INC: alu_out = alu_arg1 + 16'd1;
            OP_DEC: alu_out = alu_arg1 - 16'd1;
            OP_DEC_LD: begin
                alu_out       = alu_arg1 - 16'd1;
                alu_flags_out = {alu_flags_in[7:5], 1'b0, alu_flags_in[3],
                                 alu_arg1 != 16'd1, 1'b0, alu_flags_in[0]};
            end
            default: ;
        endcase
    end

    task automatic model_xfer(input logic [1:0] m, input logic [15:0] b, d, h,
                              input logic [7:0] a, f, input int rdd, wrd);
        logic [7:0] v, n;
        int nbytes = 0;
        exp_addr.delete(); exp_dat.delete(); ovl.delete();
        forever begin
            v = ovl.exists(h) ? ovl[h] : mem[h];
            ovl[d] = v;
            exp_addr.push_back(d);
            exp_dat.push_back(v);
            h = m[0] ? h - 16'd1 : h + 16'd1;
            d = m[0] ? d - 16'd1 : d + 16'd1;
            b = b - 16'd1;
            n = v + a;
            f = {f[7:6], n[1], 1'b0, n[3], b != 16'd0, 1'b0, f[0]};
            nbytes++;
            if (!(m[1] && b != 16'd0)) break;
        end
        exp_hl = h; exp_de = d; exp_bc = b; exp_f = f;
        exp_cyc = 1 + nbytes * (5 + rdd + wrd);
    endtask

    task automatic run_xfer(input logic [1:0] m, input logic [15:0] b, d, h,
                            input logic [7:0] a, f, input int rdd, wrd, input bit poke, stray);
        int rd_cnt = 0, wr_cnt = 0;
        logic [15:0] hold_addr = 16'd0;
        logic [7:0]  hold_dat = 8'd0;
        bit seen = 0;
        got_addr.delete(); got_dat.delete();
        proto_err = 0; run_to = 0;
        @(negedge clk);
        mode = m; bc_in = b; de_in = d; hl_in = h; a_in = a; flags_in = f; start = 1'b1;
        @(posedge clk);
        run_cyc = 1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); bc_in = 16'($urandom); de_in = 16'($urandom);
        hl_in = 16'($urandom); a_in = 8'($urandom); flags_in = 8'($urandom);
        while (!seen) begin
            start = poke && (run_cyc == 2);
            mem_rd_ack = 1'b0; mem_wr_ack = 1'b0; mem_rd_data = 8'($urandom);
            if (!busy) proto_err++;
            if (mem_rd_req && mem_wr_req) proto_err++;
            if (mem_rd_req) begin
                if (rd_cnt > 0 && mem_addr !== hold_addr) proto_err++;
                hold_addr = mem_addr;
                rd_cnt++;
                if (rd_cnt > rdd) begin
                    mem_rd_ack = 1'b1;
                    mem_rd_data = mem[mem_addr];
                end
            end else begin
                rd_cnt = 0;
                mem_rd_ack = stray;
            end
            if (mem_wr_req) begin
                if (wr_cnt > 0 && (mem_addr !== hold_addr || mem_wr_data !== hold_dat)) proto_err++;
                hold_addr = mem_addr;
                hold_dat = mem_wr_data;
                wr_cnt++;
                if (wr_cnt > wrd) begin
                    mem_wr_ack = 1'b1;
                    mem[mem_addr] = mem_wr_data;
                    got_addr.push_back(mem_addr);
                    got_dat.push_back(mem_wr_data);
                end
            end else begin
                wr_cnt = 0;
                mem_wr_ack = stray;
            end
            if (done) seen = 1;
            else if (run_cyc >= 400) begin run_to = 1; seen = 1; end
            else begin
                @(posedge clk);
                run_cyc++;
                @(negedge clk);
            end
        end
        mem_rd_ack = 1'b0; mem_wr_ack = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        done_after = done; busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({mem_rd_req, mem_wr_req, busy, done} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {mem_rd_req, mem_wr_req, busy, done}); end
        total++; if ({bc_out, de_out, hl_out, flags_out, mem_addr, mem_wr_data} !== 88'd0) begin
            bad++; $display("FAIL reset_regs: got %h want 0", {bc_out, de_out, hl_out, flags_out, mem_addr, mem_wr_data}); end
        total++; if ({alu_arg1, alu_op, alu_flags_in} !== {16'd0, OP_INC, 8'd0}) begin
            bad++; $display("FAIL reset_alu: got %h want %h", {alu_arg1, alu_op, alu_flags_in}, {16'd0, OP_INC, 8'd0}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({busy, mem_rd_req, mem_wr_req} !== 3'b000) begin
            bad++; $display("FAIL reset_idle: got %b want 000", {busy, mem_rd_req, mem_wr_req}); end
    endtask

    task automatic test_ldi();
        mem[16'h1000] = 8'h0A;
        run_xfer(2'b00, 16'h0001, 16'h2000, 16'h1000, 8'h00, 8'h00, 0, 0, 0, 0);
        total++; if (run_to || run_cyc != 6) begin
            bad++; $display("FAIL ldi_cycles: got %0d timeout=%0d want 6", run_cyc, run_to); end
        total++; if (got_addr.size() != 1 || got_addr[0] !== 16'h2000 || got_dat[0] !== 8'h0A) begin
            bad++; $display("FAIL ldi_write: n=%0d %h@%h want 1 write 0a@2000", got_addr.size(), got_dat[0], got_addr[0]); end
        total++; if ({hl_out, de_out, bc_out} !== {16'h1001, 16'h2001, 16'h0000}) begin
            bad++; $display("FAIL ldi_regs: got %h %h %h want 1001 2001 0000", hl_out, de_out, bc_out); end
        total++; if (flags_out !== 8'h28) begin
            bad++; $display("FAIL ldi_flags: got %h want 28", flags_out); end
        total++; if ({proto_err != 0, done_after, busy_after} !== 3'b000) begin
            bad++; $display("FAIL ldi_proto: err=%0d done_after=%0d busy_after=%0d want 0 0 0", proto_err, done_after, busy_after); end
    endtask

    task automatic test_ldir();
        mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22; mem[16'h1002] = 8'h33;
        run_xfer(2'b10, 16'h0003, 16'h2000, 16'h1000, 8'h00, 8'h00, 0, 0, 0, 0);
        total++; if (run_to || run_cyc != 16) begin
            bad++; $display("FAIL ldir_cycles: got %0d want 16", run_cyc); end
        total++; if (got_addr.size() != 3 || {got_addr[0], got_dat[0], got_addr[1], got_dat[1], got_addr[2], got_dat[2]}
                     !== {16'h2000, 8'h11, 16'h2001, 8'h22, 16'h2002, 8'h33}) begin
            bad++; $display("FAIL ldir_writes: n=%0d first %h@%h last %h@%h", got_addr.size(), got_dat[0], got_addr[0], got_dat[2], got_addr[2]); end
        total++; if ({bc_out, hl_out, de_out} !== {16'h0000, 16'h1003, 16'h2003}) begin
            bad++; $display("FAIL ldir_regs: got bc=%h hl=%h de=%h want 0000 1003 2003", bc_out, hl_out, de_out); end
    endtask

    task automatic test_lddr();
        // The first write lands on 0x0000, which is the second source byte
        mem[16'h0001] = 8'hA1; mem[16'h0000] = 8'hB2;
        run_xfer(2'b11, 16'h0002, 16'h0000, 16'h0001, 8'h00, 8'h00, 0, 0, 0, 0);
        total++; if (got_addr.size() != 2 || {got_addr[0], got_dat[0], got_addr[1], got_dat[1]}
                     !== {16'h0000, 8'hA1, 16'hFFFF, 8'hA1}) begin
            bad++; $display("FAIL lddr_writes: n=%0d %h@%h %h@%h want a1@0000 a1@ffff", got_addr.size(), got_dat[0], got_addr[0], got_dat[1], got_addr[1]); end
        total++; if ({hl_out, de_out, bc_out} !== {16'hFFFF, 16'hFFFE, 16'h0000} || run_cyc != 11) begin
            bad++; $display("FAIL lddr_regs: got hl=%h de=%h bc=%h cyc=%0d want ffff fffe 0000 11", hl_out, de_out, bc_out, run_cyc); end
    endtask

    task automatic test_wait();
        mem[16'h3000] = 8'h5C;
        run_xfer(2'b00, 16'h0001, 16'h4000, 16'h3000, 8'h00, 8'h00, 3, 2, 0, 0);
        total++; if (run_to || run_cyc != 11) begin
            bad++; $display("FAIL wait_cycles: got %0d want 11", run_cyc); end
        total++; if (proto_err != 0 || got_addr.size() != 1 || got_addr[0] !== 16'h4000 || got_dat[0] !== 8'h5C) begin
            bad++; $display("FAIL wait_data: err=%0d n=%0d %h@%h want 5c@4000", proto_err, got_addr.size(), got_dat[0], got_addr[0]); end
    endtask

    task automatic test_bc_zero();
        mem[16'hFFFF] = 8'h33;
        run_xfer(2'b00, 16'h0000, 16'h7FFF, 16'hFFFF, 8'h10, 8'hC1, 0, 0, 0, 0);
        total++; if ({bc_out, hl_out, de_out} !== {16'hFFFF, 16'h0000, 16'h8000}) begin
            bad++; $display("FAIL bc0_regs: got bc=%h hl=%h de=%h want ffff 0000 8000", bc_out, hl_out, de_out); end
        total++; if (flags_out !== 8'hE5 || run_cyc != 6) begin
            bad++; $display("FAIL bc0_flags: got f=%h cyc=%0d want e5 6", flags_out, run_cyc); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mode = 2'b10; bc_in = 16'h0005; de_in = 16'h6000; hl_in = 16'h5000; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; mem_rd_ack = 1'b1; mem_rd_data = 8'h5A;
        @(posedge clk); @(negedge clk);
        mem_rd_ack = 1'b0;
        total++; if ({mem_wr_req, mem_wr_data, mem_addr} !== {1'b1, 8'h5A, 16'h6000}) begin
            bad++; $display("FAIL mid_write: req=%0d data=%h addr=%h want 1 5a 6000", mem_wr_req, mem_wr_data, mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({mem_wr_req, mem_rd_req, busy, done, bc_out, de_out, hl_out, flags_out, mem_addr, mem_wr_data} !== 92'd0) begin
            bad++; $display("FAIL mid_reset: req=%0d busy=%0d regs=%h want all 0", mem_wr_req, busy, {bc_out, de_out, hl_out, flags_out, mem_addr, mem_wr_data}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({mem_rd_req, mem_wr_req, busy} !== 3'b000) begin
            bad++; $display("FAIL mid_quiet: got %b want 000", {mem_rd_req, mem_wr_req, busy}); end
        model_xfer(2'b00, 16'h0004, 16'h6100, 16'h5100, 8'h07, 8'h00, 0, 0);
        run_xfer(2'b00, 16'h0004, 16'h6100, 16'h5100, 8'h07, 8'h00, 0, 0, 0, 0);
        total++; if ({hl_out, de_out, bc_out, flags_out} !== {exp_hl, exp_de, exp_bc, exp_f} || run_cyc != exp_cyc) begin
            bad++; $display("FAIL mid_rerun: got %h cyc=%0d want %h cyc=%0d", {hl_out, de_out, bc_out, flags_out}, run_cyc, {exp_hl, exp_de, exp_bc, exp_f}, exp_cyc); end
    endtask

    task automatic test_busy_start();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] b, d, h;
            logic [7:0]  a, f;
            logic [1:0]  m;
            m = 2'($urandom); b = 16'($urandom_range(1, 3)); d = 16'($urandom); h = 16'($urandom);
            a = 8'($urandom); f = 8'($urandom);
            model_xfer(m, b, d, h, a, f, 1, 1);
            run_xfer(m, b, d, h, a, f, 1, 1, 1, 1);
            total++; if ({hl_out, de_out, bc_out, flags_out} !== {exp_hl, exp_de, exp_bc, exp_f}
                         || run_cyc != exp_cyc || got_dat.size() != exp_dat.size()) begin
                bad++; $display("FAIL busy_start%0d: got %h cyc=%0d n=%0d want %h cyc=%0d n=%0d", k,
                    {hl_out, de_out, bc_out, flags_out}, run_cyc, got_dat.size(), {exp_hl, exp_de, exp_bc, exp_f}, exp_cyc, exp_dat.size()); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            logic [15:0] b, d, h;
            logic [7:0]  a, f;
            logic [1:0]  m;
            int rdd, wrd;
            m = 2'($urandom); d = 16'($urandom); h = 16'($urandom);
            b = m[1] ? 16'($urandom_range(1, 4)) : 16'($urandom);
            if (k % 6 == 0) h = d + 16'd1;
            a = 8'($urandom); f = 8'($urandom);
            rdd = $urandom_range(0, 3); wrd = $urandom_range(0, 3);
            model_xfer(m, b, d, h, a, f, rdd, wrd);
            run_xfer(m, b, d, h, a, f, rdd, wrd, 0, k[0]);
            total++; if (run_to || run_cyc != exp_cyc) begin
                bad++; $display("FAIL rand%0d_cycles: got %0d want %0d", k, run_cyc, exp_cyc); end
            total++; if (got_addr.size() != exp_addr.size()) begin
                bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", k, got_addr.size(), exp_addr.size()); end
            else for (int i = 0; i < exp_addr.size(); i++) begin
                total++; if ({got_addr[i], got_dat[i]} !== {exp_addr[i], exp_dat[i]}) begin
                    bad++; $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h", k, i, got_dat[i], got_addr[i], exp_dat[i], exp_addr[i]); end
            end
            total++; if ({hl_out, de_out, bc_out, flags_out} !== {exp_hl, exp_de, exp_bc, exp_f}) begin
                bad++; $display("FAIL rand%0d_regs: got %h want %h", k, {hl_out, de_out, bc_out, flags_out}, {exp_hl, exp_de, exp_bc, exp_f}); end
            total++; if (proto_err != 0 || done_after || busy_after) begin
                bad++; $display("FAIL rand%0d_proto: err=%0d done_after=%0d busy_after=%0d want 0 0 0", k, proto_err, done_after, busy_after); end
        end
    endtask

    task automatic test_idle_stray();
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rd_ack = 1'b1; mem_wr_ack = 1'b1; mem_rd_data = 8'($urandom);
            @(negedge clk);
            total++; if ({busy, done, mem_rd_req, mem_wr_req} !== 4'b0) begin
                bad++; $display("FAIL stray%0d_ctrl: got %b want 0000", i, {busy, done, mem_rd_req, mem_wr_req}); end
        end
        mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
        total++; if ({hl_out, de_out, bc_out, flags_out} !== {exp_hl, exp_de, exp_bc, exp_f}) begin
            bad++; $display("FAIL stray_regs: got %h want %h", {hl_out, de_out, bc_out, flags_out}, {exp_hl, exp_de, exp_bc, exp_f}); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_ldi();
        test_ldir();
        test_lddr();
        test_wait();
        test_bc_zero();
        test_reset_mid();
        test_busy_start();
        test_random();
        test_idle_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ldx_seq.md
LDX_SEQ -- requirements
Module: ldx_seq

Interface
REQ-001 Parameter OP_INC, default 3'd0: alu16 op code for 16-bit increment.
REQ-002 Parameter OP_DEC, default 3'd1: alu16 op code for 16-bit decrement.
REQ-003 Parameter OP_DEC_LD, default 3'd3: alu16 op code for the block-transfer BC decrement with flags.
REQ-004 Clock and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-005 Ports, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  begin transfer; sampled in IDLE only
- mode  in  2  bit0=1 decrement (LDD), 0 increment (LDI); bit1=1 repeat (LDIR/LDDR)
- bc_in, de_in, hl_in  in  16 each  initial BC/DE/HL
- a_in  in  8  accumulator, for F5/F3
- flags_in  in  8  initial F
- mem_addr  out  16  memory address
- mem_rd_req  out  1  read request
- mem_rd_ack  in  1  read data valid this cycle
- mem_rd_data  in  8  read data
- mem_wr_req  out  1  write request
- mem_wr_data  out  8  write data
- mem_wr_ack  in  1  write accepted this cycle
- alu_arg1  out  16  to alu16_arg1
- alu_op  out  3  to alu16_op
- alu_flags_in  out  8  to alu16_flags_in
- alu_out  in  16  from alu16_out
- alu_flags_out  in  8  from alu16_flags_out
- bc_out, de_out, hl_out  out  16 each  working registers
- flags_out  out  8  working F
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Function
REQ-006 States SHALL be IDLE, READ, WRITE, UPD_HL, UPD_DE, UPD_BC, DONE; all registered outputs change only on rising clk.
REQ-007 In IDLE with start=1, the block SHALL load bc/de/hl/flags and a_in into working registers, capture mode, and enter READ next cycle.
REQ-008 In READ: mem_addr=hl_out and mem_rd_req=1; on mem_rd_ack=1, latch mem_rd_data into the data register and go to WRITE; otherwise hold.
REQ-009 In WRITE: mem_addr=de_out, mem_wr_req=1, and mem_wr_data=the data register; on mem_wr_ack=1, go to UPD_HL; otherwise hold.
REQ-010 Requests SHALL be held until acknowledged; an ack outside its own state SHALL be ignored.
REQ-011 In UPD_HL: alu_arg1=hl_out, alu_op=OP_DEC if mode[0] else OP_INC; latch alu_out into hl_out; go to UPD_DE.
REQ-012 In UPD_DE: the same as REQ-011 applied to de_out; go to UPD_BC.
REQ-013 In UPD_BC: alu_arg1=bc_out, alu_op=OP_DEC_LD, alu_flags_in=flags_out; latch alu_out into bc_out.
REQ-014 In UPD_BC, latch alu_flags_out into flags_out, with bit5 replaced by n[1] and bit3 by n[3], where n = data + a (8-bit, wraps).
REQ-015 From UPD_BC: if mode[1]=1 and alu_out!=0, go to READ; otherwise go to DONE.
REQ-016 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-017 busy=1 in every state except IDLE.
REQ-018 With zero-wait acks, one byte SHALL take 5 cycles (READ to UPD_BC); start-to-done for a single byte is 6 cycles.
REQ-019 BC=0x0000 with repeat SHALL wrap to 0xFFFF and transfer 65536 bytes; 16-bit addresses wrap modulo 2^16.
REQ-020 start while busy=1 SHALL be ignored; outputs hold between transfers.
REQ-021 In non-UPD states, alu_arg1=0, alu_op=OP_INC, and alu_flags_in=flags_out.

Reset
REQ-022 rst_n=0 SHALL asynchronously force IDLE, drop any request, and clear bc/de/hl_out, flags_out, the data register, mem_addr, mem_wr_data, busy, and done to 0.
REQ-023 Reset mid-transfer SHALL abandon the transfer with no further memory requests.

Verification
REQ-024 LDI with HL=0x1000, DE=0x2000, BC=0x0001, A=0x00, mem[0x1000]=0x0A, zero-wait -> write 0x0A@0x2000; HL=0x1001, DE=0x2001, BC=0; F: PV=0, H=0, N=0, F3=1, F5=1; done at cycle 6.
REQ-025 LDIR with BC=0x0003 from 0x1000 to 0x2000 -> three writes in order, done after 16 cycles, BC=0, HL=0x1003.
REQ-026 LDDR with HL=0x0001, DE=0x0000, BC=0x0002 -> writes at 0x0000 then 0xFFFF, HL=0xFFFF, DE=0xFFFE.
REQ-027 rd_ack delayed 3 cycles and wr_ack delayed 2 cycles -> requests held steady, data correct, done at cycle 11.
REQ-028 rst_n low during WRITE -> mem_wr_req=0 immediately and all outputs 0; a subsequent start runs normally.
REQ-029 start pulsed while busy, plus a stray ack in IDLE -> no effect on state or registers.
